// File: rtl/mc_pkg.sv
// Shared types for the PE stream multicaster: delivery modes, weight-buffer states, config widths.
package mc_pkg;

    localparam int KS_WIDTH = 8;

    typedef enum logic [1:0] {
        UNICAST   = 2'd0,
        MULTICAST = 2'd1,
        BROADCAST = 2'd2
    } mc_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } wbuf_state_e;

endpackage

// File: rtl/mc_skid_fifo.sv
// Small power-of-two operand FIFO. Registered read path (no bypass); a pop and a push
// in the same cycle are both honoured, even when full.
module mc_skid_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

endmodule

// File: rtl/pe_stream_multicaster.sv
// Bus-to-PE multicaster: tag-matched ifmap/psum FIFOs, cyclic weight replay buffer, result return.
// Optional MC_PERF_CNT_EN adds saturating fire/stall counters (perf_fire, perf_stall).
module pe_stream_multicaster
    import mc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int TAG_WIDTH  = 4,
    parameter int WBUF_DEPTH = 16,
    parameter int FIFO_DEPTH = 2,
    localparam int IW = $clog2(NUM_COL),
    localparam int PW = $clog2(WBUF_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cfg_load,
    input  logic [TAG_WIDTH-1:0]    cfg_tag,
    input  logic [IW-1:0]           cfg_id,
    input  logic [KS_WIDTH-1:0]     cfg_ks,
    input  logic [1:0]              cfg_mode,
    input  logic [TAG_WIDTH-1:0]    bus_tag,
    input  logic [IW-1:0]           bus_id,
    input  logic                    if_valid,
    input  logic [DATA_WIDTH-1:0]   if_data,
    output logic                    if_ready,
    input  logic                    ps_valid,
    input  logic [2*DATA_WIDTH-1:0] ps_data,
    output logic                    ps_ready,
    input  logic                    w_valid,
    input  logic [DATA_WIDTH-1:0]   w_data,
    output logic                    w_ready,
    output logic                    flush_busy,
    output logic                    pe_en,
    output logic [DATA_WIDTH-1:0]   pe_ifmap,
    output logic [DATA_WIDTH-1:0]   pe_fltr,
    output logic [2*DATA_WIDTH-1:0] pe_psum,
    input  logic                    pe_valid,
    input  logic [2*DATA_WIDTH-1:0] pe_result,
    output logic                    pe_stall,
    output logic                    res_valid,
    output logic [2*DATA_WIDTH-1:0] res_data,
    output logic [IW-1:0]           res_id,
    input  logic                    res_ready
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]             perf_fire,
    output logic [31:0]             perf_stall
`endif
);

    // Last replay index; zero weights behaves as one, oversize passes clamp to the buffer.
    function automatic logic [PW-1:0] ks_last_f(input logic [KS_WIDTH-1:0] ks);
        if (ks == '0) return '0;
        if (int'(ks) >= WBUF_DEPTH) return PW'(WBUF_DEPTH - 1);
        return PW'(ks - 1'b1);
    endfunction

    logic [TAG_WIDTH-1:0]    tag_q;
    logic [IW-1:0]           id_q;
    logic [1:0]              mode_q;
    logic [PW-1:0]           ks_last_q;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    wbuf_state_e             state, state_nxt;
    logic                    wbuf_we;
    logic [DATA_WIDTH-1:0]   wbuf [WBUF_DEPTH];

    logic                    match;
    logic                    if_empty, if_full, ps_empty, ps_full;
    logic                    if_push, ps_push;
    logic [DATA_WIDTH-1:0]   if_head;
    logic [2*DATA_WIDTH-1:0] ps_head;

    always_comb begin
        match = 1'b0;
        case (mc_mode_e'(mode_q))
            MULTICAST: match = (bus_tag == tag_q);
            BROADCAST: match = 1'b1;
            default:   match = (bus_tag == tag_q) && (bus_id == id_q);
        endcase
    end

    // A pop in the same cycle frees the slot, so a full FIFO can still take a matching beat.
    assign if_ready = ~match | ~if_full | pe_en;
    assign ps_ready = ~match | ~ps_full | pe_en;
    assign if_push  = if_valid & match & (~if_full | pe_en);
    assign ps_push  = ps_valid & match & (~ps_full | pe_en);

    mc_skid_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_if_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (if_push),
        .pop   (pe_en),
        .wdata (if_data),
        .rdata (if_head),
        .empty (if_empty),
        .full  (if_full)
    );

    mc_skid_fifo #(.WIDTH(2*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_ps_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (ps_push),
        .pop   (pe_en),
        .wdata (ps_data),
        .rdata (ps_head),
        .empty (ps_empty),
        .full  (ps_full)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wbuf_we   = 1'b0;
        if (cfg_load) begin
            state_nxt = LOAD;
        end else if (state == LOAD && w_valid) begin
            wbuf_we = 1'b1;
            if (wr_ptr == ks_last_q) state_nxt = RUN;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_q     <= '0;
            id_q      <= '0;
            mode_q    <= '0;
            ks_last_q <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else if (cfg_load) begin
            tag_q     <= cfg_tag;
            id_q      <= cfg_id;
            mode_q    <= cfg_mode;
            ks_last_q <= ks_last_f(cfg_ks);
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            if (wbuf_we) wr_ptr <= wr_ptr + 1'b1;
            if (pe_en)   rd_ptr <= (rd_ptr == ks_last_q) ? '0 : rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wbuf_we) wbuf[wr_ptr] <= w_data;
    end

    assign w_ready    = (state == LOAD);
    assign flush_busy = (state == LOAD);
    assign pe_en      = (state == RUN) & ~if_empty & ~ps_empty & ~pe_stall;
    assign pe_ifmap   = if_empty ? '0 : if_head;
    assign pe_psum    = ps_empty ? '0 : ps_head;
    assign pe_fltr    = (state == RUN) ? wbuf[rd_ptr] : '0;

    // Result holding register; draining and refilling in one cycle keeps full throughput.
    assign pe_stall = res_valid & ~res_ready;
    assign res_id   = id_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else if (pe_valid && !pe_stall) begin
            res_valid <= 1'b1;
            res_data  <= pe_result;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_fire  <= '0;
            perf_stall <= '0;
        end else if (cfg_load) begin
            perf_fire  <= '0;
            perf_stall <= '0;
        end else begin
            if (pe_en && perf_fire != '1) perf_fire <= perf_fire + 1'b1;
            if (state == RUN && !pe_en && perf_stall != '1) perf_stall <= perf_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_stream_multicaster.sv
// Scoreboard bench for pe_stream_multicaster: directed stimulus queues expected PE operands and
// bus results; a negedge monitor pops and compares whenever the DUT fires or returns a result.
module tb_pe_stream_multicaster;

    localparam int DW = 16;
    localparam int IW = 2;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cfg_load;
    logic [TW-1:0] cfg_tag;
    logic [IW-1:0] cfg_id;
    logic [7:0]    cfg_ks;
    logic [1:0]    cfg_mode;
    logic [TW-1:0] bus_tag;
    logic [IW-1:0] bus_id;
    logic          if_valid;
    logic [DW-1:0] if_data;
    logic          if_ready;
    logic          ps_valid;
    logic [2*DW-1:0] ps_data;
    logic          ps_ready;
    logic          w_valid;
    logic [DW-1:0] w_data;
    logic          w_ready;
    logic          flush_busy;
    logic          pe_en;
    logic [DW-1:0] pe_ifmap;
    logic [DW-1:0] pe_fltr;
    logic [2*DW-1:0] pe_psum;
    logic          pe_valid;
    logic [2*DW-1:0] pe_result;
    logic          pe_stall;
    logic          res_valid;
    logic [2*DW-1:0] res_data;
    logic [IW-1:0] res_id;
    logic          res_ready;
`ifdef MC_PERF_CNT_EN
    logic [31:0]   perf_fire;
    logic [31:0]   perf_stall;
`endif

    pe_stream_multicaster #(
        .DATA_WIDTH (16),
        .NUM_COL    (4),
        .TAG_WIDTH  (4),
        .WBUF_DEPTH (16),
        .FIFO_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cfg_load   (cfg_load),
        .cfg_tag    (cfg_tag),
        .cfg_id     (cfg_id),
        .cfg_ks     (cfg_ks),
        .cfg_mode   (cfg_mode),
        .bus_tag    (bus_tag),
        .bus_id     (bus_id),
        .if_valid   (if_valid),
        .if_data    (if_data),
        .if_ready   (if_ready),
        .ps_valid   (ps_valid),
        .ps_data    (ps_data),
        .ps_ready   (ps_ready),
        .w_valid    (w_valid),
        .w_data     (w_data),
        .w_ready    (w_ready),
        .flush_busy (flush_busy),
        .pe_en      (pe_en),
        .pe_ifmap   (pe_ifmap),
        .pe_fltr    (pe_fltr),
        .pe_psum    (pe_psum),
        .pe_valid   (pe_valid),
        .pe_result  (pe_result),
        .pe_stall   (pe_stall),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_ready  (res_ready)
`ifdef MC_PERF_CNT_EN
        ,
        .perf_fire  (perf_fire),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0]   exp_if [$];
    logic [2*DW-1:0] exp_ps [$];
    logic [DW-1:0]   exp_fl [$];
    logic [33:0]     exp_res [$];
    logic [33:0]     mon_r;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (pe_en) begin
                if (exp_if.size() == 0 || exp_ps.size() == 0 || exp_fl.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pe_en_unexpected: got pe_en=1, expected no fire");
                end else begin
                    chk("pe_ifmap", pe_ifmap, exp_if.pop_front());
                    chk("pe_psum", pe_psum, exp_ps.pop_front());
                    chk("pe_fltr", pe_fltr, exp_fl.pop_front());
                end
            end
            if (res_valid && res_ready) begin
                if (exp_res.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL res_unexpected: got res %0h, expected none", res_data);
                end else begin
                    mon_r = exp_res.pop_front();
                    chk("res_data", res_data, mon_r[31:0]);
                    chk("res_id", res_id, mon_r[33:32]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [7:0] ks, input logic [1:0] mode,
                          input logic [TW-1:0] tg, input logic [IW-1:0] id);
        cfg_ks = ks; cfg_mode = mode; cfg_tag = tg; cfg_id = id;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic load_w(input int n, input logic [DW-1:0] base, input logic [DW-1:0] step);
        for (int i = 0; i < n; i++) begin
            w_valid = 1'b1;
            w_data  = base + DW'(i) * step;
            tick();
        end
        w_valid = 1'b0;
    endtask

    task automatic push_pair(input bit do_if, input bit do_ps, input logic [DW-1:0] ifd,
                             input logic [2*DW-1:0] psd, input logic [TW-1:0] tg,
                             input logic [IW-1:0] id, input logic [DW-1:0] fl, input bit fire);
        bit pi, pp, ai, ap;
        int k;
        pi = do_if; pp = do_ps;
        if (do_if) exp_if.push_back(ifd);
        if (do_ps) exp_ps.push_back(psd);
        if (fire)  exp_fl.push_back(fl);
        bus_tag = tg; bus_id = id; if_data = ifd; ps_data = psd;
        if_valid = pi; ps_valid = pp;
        k = 0;
        while ((pi || pp) && k < 20) begin
            @(negedge clk);
            ai = pi & if_ready;
            ap = pp & ps_ready;
            tick();
            if (ai) pi = 1'b0;
            if (ap) pp = 1'b0;
            if_valid = pi; ps_valid = pp;
            k++;
        end
        if_valid = 1'b0; ps_valid = 1'b0;
        chk("push_accepted", {62'd0, pi, pp}, 64'd0);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_flush_busy"}, flush_busy, 0);
        chk({pfx, "_w_ready"}, w_ready, 0);
        chk({pfx, "_pe_en"}, pe_en, 0);
        chk({pfx, "_pe_stall"}, pe_stall, 0);
        chk({pfx, "_res_valid"}, res_valid, 0);
        chk({pfx, "_res_data"}, res_data, 0);
        chk({pfx, "_res_id"}, res_id, 0);
        chk({pfx, "_pe_fltr"}, pe_fltr, 0);
        chk({pfx, "_pe_ifmap"}, pe_ifmap, 0);
        chk({pfx, "_pe_psum"}, pe_psum, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; cfg_load = 1'b0; cfg_tag = '0; cfg_id = '0; cfg_ks = '0; cfg_mode = '0;
        bus_tag = '0; bus_id = '0; if_valid = 1'b0; if_data = '0; ps_valid = 1'b0; ps_data = '0;
        w_valid = 1'b0; w_data = '0; pe_valid = 1'b0; pe_result = '0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rstn = 1'b1;
        tick();

        // ks=3 load, then cyclic replay 5,6,7,5,6,7
        do_cfg(8'd3, 2'd0, 4'd2, 2'd1);
        w_valid = 1'b1; w_data = 16'd5;
        @(negedge clk);
        chk("t1_flush_busy_load", flush_busy, 1);
        chk("t1_w_ready", w_ready, 1);
        tick();
        w_data = 16'd6; tick();
        w_data = 16'd7; tick();
        w_valid = 1'b0;
        @(negedge clk);
        chk("t1_flush_busy_done", flush_busy, 0);
        chk("t1_w_ready_run", w_ready, 0);
        tick();
        for (int i = 0; i < 6; i++)
            push_pair(1, 1, 16'h10 + 16'(i), 32'h100 + 32'(i), 4'd2, 2'd1, 16'(5 + i % 3), 1);
        repeat (3) tick();

        // unicast filtering
        bus_tag = 4'd2; bus_id = 2'd3; if_data = 16'hdead; if_valid = 1'b1;
        @(negedge clk);
        chk("t2_if_ready_nomatch", if_ready, 1);
        tick();
        if_valid = 1'b0;
        push_pair(0, 1, 16'h0, 32'h200, 4'd2, 2'd1, 16'h0, 0);
        repeat (2) tick();
        @(negedge clk);
        chk("t2_no_fire", pe_en, 0);
        tick();
        push_pair(1, 0, 16'h21, 32'h0, 4'd2, 2'd1, 16'd5, 1);
        repeat (2) tick();

        // result back-pressure
        res_ready = 1'b0; pe_valid = 1'b1; pe_result = 32'hAAAA0001;
        exp_res.push_back({2'd1, 32'hAAAA0001});
        tick();
        pe_result = 32'hBBBB0002;
        @(negedge clk);
        chk("t3_pe_stall", pe_stall, 1);
        chk("t3_res_valid", res_valid, 1);
        tick();
        push_pair(1, 1, 16'h31, 32'h301, 4'd2, 2'd1, 16'd6, 1);
        @(negedge clk);
        chk("t3_no_fire_stall", pe_en, 0);
        tick();
        res_ready = 1'b1;
        exp_res.push_back({2'd1, 32'hBBBB0002});
        tick();
        pe_valid = 1'b0;
        repeat (3) tick();

        // ifmap full, psum empty
        push_pair(1, 0, 16'h41, 32'h0, 4'd2, 2'd1, 16'h0, 0);
        push_pair(1, 0, 16'h42, 32'h0, 4'd2, 2'd1, 16'h0, 0);
        bus_tag = 4'd2; bus_id = 2'd1; if_data = 16'h43; if_valid = 1'b1;
        @(negedge clk);
        chk("t4_if_ready_full", if_ready, 0);
        chk("t4_no_fire", pe_en, 0);
        bus_id = 2'd3;
        #1;
        chk("t4_if_ready_nomatch_full", if_ready, 1);
        tick();
        if_valid = 1'b0;
        bus_id = 2'd1; ps_data = 32'h401; ps_valid = 1'b1;
        exp_ps.push_back(32'h401);
        exp_fl.push_back(16'd7);
        @(negedge clk);
        chk("t4_ps_ready", ps_ready, 1);
        chk("t4_fire_delay", pe_en, 0);
        tick();
        ps_valid = 1'b0;
        @(negedge clk);
        chk("t4_fire", pe_en, 1);
        tick();

        // reload mid-RUN, broadcast, ks=2
        do_cfg(8'd2, 2'd2, 4'd7, 2'd1);
        push_pair(0, 1, 16'h0, 32'h402, 4'd9, 2'd3, 16'h11, 1);
        @(negedge clk);
        chk("t5_flush_busy", flush_busy, 1);
        chk("t5_no_fire_load", pe_en, 0);
        tick();
        load_w(2, 16'h11, 16'h11);
        @(negedge clk);
        chk("t5_flush_done", flush_busy, 0);
        chk("t5_fire", pe_en, 1);
        tick();
        push_pair(1, 1, 16'h51, 32'h501, 4'd9, 2'd3, 16'h22, 1);
        push_pair(1, 1, 16'h52, 32'h502, 4'd9, 2'd3, 16'h11, 1);
        repeat (3) tick();

        // ks=0 behaves as one weight; reserved mode acts as unicast
        do_cfg(8'd0, 2'd3, 4'd2, 2'd1);
        load_w(1, 16'h55, 16'h0);
        @(negedge clk);
        chk("t6_ks0_done", flush_busy, 0);
        tick();
        push_pair(1, 1, 16'h61, 32'h601, 4'd2, 2'd1, 16'h55, 1);
        push_pair(1, 1, 16'h62, 32'h602, 4'd2, 2'd1, 16'h55, 1);
        repeat (3) tick();

        // reset mid-LOAD, then full-depth pass
        chk("pre_rst_queues", 64'(exp_if.size() + exp_ps.size() + exp_fl.size() + exp_res.size()), 0);
        do_cfg(8'd16, 2'd0, 4'd2, 2'd1);
        load_w(5, 16'h300, 16'h1);
        w_valid = 1'b1; w_data = 16'h3ff;
        rstn = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        tick();
        tick();
        w_valid = 1'b0;
        rstn = 1'b1;
        tick();
        @(negedge clk);
        chk_reset_outputs("post_rst");
        tick();
        do_cfg(8'd16, 2'd0, 4'd2, 2'd1);
        load_w(16, 16'h100, 16'h1);
        @(negedge clk);
        chk("t7_flush_done", flush_busy, 0);
        tick();
        for (int i = 0; i < 17; i++)
            push_pair(1, 1, 16'h700 + 16'(i), 32'h7000 + 32'(i), 4'd2, 2'd1, 16'h100 + 16'(i % 16), 1);
        repeat (4) tick();

        chk("end_if_queue", 64'(exp_if.size()), 0);
        chk("end_ps_queue", 64'(exp_ps.size()), 0);
        chk("end_fl_queue", 64'(exp_fl.size()), 0);
        chk("end_res_queue", 64'(exp_res.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
